// File: rtl/mac_pkg.sv
// mac_pkg: shared types and helpers for the mac_stream engine.
//   BEAT_W        width of the per-frame beat counter
//   MAX_ACC_W     widest accumulator the saturate helper supports
//   fifo_entry_w  packed width of one {last, signals, coeffs} FIFO entry
//   lane_lo       bit offset of a lane inside a packed lane vector
//   beat_inc      saturating beat counter increment
//   sat_narrow    clamp a signed value into a w-bit signed range
package mac_pkg;

    localparam int BEAT_W    = 16;
    localparam int MAX_ACC_W = 128;

    function automatic int fifo_entry_w(input int width, input int lanes);
        return 1 + 2 * lanes * width;
    endfunction

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic [BEAT_W-1:0] beat_inc(input logic [BEAT_W-1:0] b);
        return (&b) ? b : b + BEAT_W'(1);
    endfunction

    // Result is still MAX_ACC_W wide; callers keep the low w bits.
    function automatic logic signed [MAX_ACC_W-1:0] sat_narrow(
        input logic signed [MAX_ACC_W-1:0] t,
        input int                          w
    );
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        hi = (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
        lo = ~hi;
        if (t > hi) begin
            return hi;
        end else if (t < lo) begin
            return lo;
        end
        return t;
    endfunction

endpackage

// File: rtl/mac_fifo.sv
// mac_fifo: generic synchronous FIFO, DEPTH a power of two.
//   clk, rst_n   clock / async active-low reset (clears pointers and count)
//   push_i       write data_i (ignored while full)
//   pop_i        drop head entry (ignored while empty)
//   data_o       head entry, valid whenever !empty_o
//   full_o       count == DEPTH
//   empty_o      count == 0
//   count_o      occupancy 0..DEPTH
module mac_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            data_i,
    output logic [DW-1:0]            data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mac_stream.sv
// mac_stream: multi-lane streaming multiply-accumulate with per-frame output.
//   clk, rst_n        clock / async active-low reset (drops any partial frame)
//   in_valid_i        beat present; accepted when in_ready_o is high
//   in_ready_o        input FIFO not full
//   in_signal_i       LANES signed WIDTH-bit elements, lane 0 in LSBs
//   in_coeff_i        LANES signed WIDTH-bit elements, lane 0 in LSBs
//   in_last_i         final beat of the frame
//   sat_en_i          1 = clamp narrowed result, 0 = truncate
//   out_valid_o       result held until out_ready_i
//   out_ready_i       consumer accepts
//   out_acc_o         full-precision frame sum
//   out_data_o        (out_acc >>> SHIFT) narrowed to WIDTH
//   out_beats_o       beats in the frame, saturating
//   out_ovf_o         accumulator wrapped at least once in the frame
// ACC_W must be >= 2*WIDTH and <= MAX_ACC_W.
module mac_stream
    import mac_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int ACC_W = 2*WIDTH+8,
    parameter int SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [LANES*WIDTH-1:0] in_signal_i,
    input  logic [LANES*WIDTH-1:0] in_coeff_i,
    input  logic                   in_last_i,
    input  logic                   sat_en_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [ACC_W-1:0]       out_acc_o,
    output logic [WIDTH-1:0]       out_data_o,
    output logic [BEAT_W-1:0]      out_beats_o,
    output logic                   out_ovf_o
);
    localparam int VW = LANES * WIDTH;
    localparam int EW = fifo_entry_w(WIDTH, LANES);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0] fifo_wdata, fifo_rdata;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0] fifo_count_unused;

    assign fifo_wdata = {in_last_i, in_signal_i, in_coeff_i};
    assign in_ready_o = !fifo_full;

    mac_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid_i),
        .pop_i   (fifo_pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    logic          pop_last;
    logic [VW-1:0] pop_sig, pop_coef;
    assign {pop_last, pop_sig, pop_coef} = fifo_rdata;

    // Lane-wise products reduced at full accumulator width.
    logic signed [ACC_W-1:0]   lane_sum;
    logic signed [WIDTH-1:0]   sig_l, coef_l;
    logic signed [2*WIDTH-1:0] prod_l;

    always_comb begin
        lane_sum = '0;
        sig_l    = '0;
        coef_l   = '0;
        prod_l   = '0;
        for (int l = 0; l < LANES; l++) begin
            sig_l    = pop_sig[lane_lo(l, WIDTH) +: WIDTH];
            coef_l   = pop_coef[lane_lo(l, WIDTH) +: WIDTH];
            prod_l   = (2*WIDTH)'(sig_l) * (2*WIDTH)'(coef_l);
            lane_sum = lane_sum + ACC_W'(prod_l);
        end
    end

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]       beats_q, beats_d;
    logic                    ovf_q, ovf_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic [BEAT_W-1:0]       out_beats_q, out_beats_d;
    logic                    out_ovf_q, out_ovf_d;

    logic                    s1_adv;
    logic signed [ACC_W-1:0] acc_sum, acc_shr;
    logic                    add_ovf;
    logic [WIDTH-1:0]        narrow;

    // Only a last beat needs the output register, so only it can stall s1.
    assign s1_adv   = s1_valid_q && !(s1_last_q && out_valid_q && !out_ready_i);
    assign fifo_pop = !fifo_empty && (!s1_valid_q || s1_adv);

    assign acc_sum = acc_q + s1_sum_q;
    assign add_ovf = (acc_q[ACC_W-1] == s1_sum_q[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign acc_shr = acc_sum >>> SHIFT;
    assign narrow  = sat_en_i ? WIDTH'(sat_narrow(MAX_ACC_W'(acc_shr), WIDTH))
                              : WIDTH'(acc_shr);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_sum_d    = s1_sum_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_data_d  = out_data_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        if (fifo_pop) begin
            s1_valid_d = 1'b1;
            s1_last_d  = pop_last;
            s1_sum_d   = lane_sum;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

        if (s1_adv) begin
            if (s1_last_q) begin
                // Loading here overrides the take above: back-to-back results.
                out_valid_d = 1'b1;
                out_acc_d   = acc_sum;
                out_data_d  = narrow;
                out_beats_d = beat_inc(beats_q);
                out_ovf_d   = ovf_q | add_ovf;
                acc_d       = '0;
                beats_d     = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d   = acc_sum;
                beats_d = beat_inc(beats_q);
                ovf_d   = ovf_q | add_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_data_q  <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_data_q  <= out_data_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_acc_o   = out_acc_q;
    assign out_data_o  = out_data_q;
    assign out_beats_o = out_beats_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed bench for mac_stream.
// Instance A (WIDTH=16, LANES=4) covers latency, framing, saturation,
// backpressure and mid-frame reset. Instance B (WIDTH=8, LANES=1, ACC_W=16)
// covers accumulator overflow: each beat adds (-128)*(-128)=16384.
module tb_mac_stream;
    localparam int AW = 16, AL = 4, AACC = 2*AW+8;
    localparam int BW = 8,  BL = 1, BACC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              a_in_valid, a_in_ready, a_in_last, a_sat_en;
    logic              a_out_valid, a_out_ready, a_out_ovf;
    logic [AL*AW-1:0]  a_sig, a_coef;
    logic [AACC-1:0]   a_out_acc;
    logic [AW-1:0]     a_out_data;
    logic [15:0]       a_out_beats;

    logic              b_in_valid, b_in_ready, b_in_last, b_sat_en;
    logic              b_out_valid, b_out_ready, b_out_ovf;
    logic [BL*BW-1:0]  b_sig, b_coef;
    logic [BACC-1:0]   b_out_acc;
    logic [BW-1:0]     b_out_data;
    logic [15:0]       b_out_beats;

    int checks = 0;
    int errors = 0;
    int n;

    mac_stream #(.WIDTH(AW), .LANES(AL), .DEPTH(4), .ACC_W(AACC), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_signal_i(a_sig), .in_coeff_i(a_coef), .in_last_i(a_in_last),
        .sat_en_i(a_sat_en),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
        .out_acc_o(a_out_acc), .out_data_o(a_out_data),
        .out_beats_o(a_out_beats), .out_ovf_o(a_out_ovf)
    );

    mac_stream #(.WIDTH(BW), .LANES(BL), .DEPTH(4), .ACC_W(BACC), .SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_signal_i(b_sig), .in_coeff_i(b_coef), .in_last_i(b_in_last),
        .sat_en_i(b_sat_en),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_acc_o(b_out_acc), .out_data_o(b_out_data),
        .out_beats_o(b_out_beats), .out_ovf_o(b_out_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [63:0] sig, input logic [63:0] coef, input logic last);
        int k;
        k = 0;
        a_in_valid = 1'b1;
        a_sig      = sig;
        a_coef     = coef;
        a_in_last  = last;
        while (!a_in_ready && k < 50) begin
            step();
            k++;
        end
        if (!a_in_ready) chk("push_a_ready", a_in_ready, 1);
        step();
        a_in_valid = 1'b0;
    endtask

    task automatic expect_a(input string tag, input logic [63:0] acc, input logic [63:0] data,
                            input logic [63:0] beats, input logic [63:0] ovf);
        int k;
        k = 0;
        while (!a_out_valid && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, a_out_valid, 1);
        chk({tag, "_acc"},   a_out_acc,   acc);
        chk({tag, "_data"},  a_out_data,  data);
        chk({tag, "_beats"}, a_out_beats, beats);
        chk({tag, "_ovf"},   a_out_ovf,   ovf);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a_in_valid = 0; a_in_last = 0; a_sat_en = 0; a_out_ready = 1;
        a_sig = '0; a_coef = '0;
        b_in_valid = 0; b_in_last = 0; b_sat_en = 0; b_out_ready = 1;
        b_sig = '0; b_coef = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_acc",   a_out_acc,   0);
        chk("rst_out_data",  a_out_data,  0);
        chk("rst_out_beats", a_out_beats, 0);
        chk("rst_out_ovf",   a_out_ovf,   0);
        chk("rst_in_ready",  a_in_ready,  1);
        chk("rst_b_ready",   b_in_ready,  1);
        step();

        // Single-beat frame: 1*5 + 2*6 + 3*7 + 4*8 = 70, visible two edges after accept.
        push_a({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1);
        chk("lat_e0", a_out_valid, 0);
        step();
        chk("lat_e1", a_out_valid, 0);
        step();
        chk("lat_e2", a_out_valid, 1);
        expect_a("single", 70, 70, 1, 0);
        chk("single_taken", a_out_valid, 0);

        // Three back-to-back beats of all ones -> 12; next frame restarts at 0.
        push_a({4{16'd1}}, {4{16'd1}}, 1'b0);
        push_a({4{16'd1}}, {4{16'd1}}, 1'b0);
        push_a({4{16'd1}}, {4{16'd1}}, 1'b1);
        expect_a("three", 12, 12, 3, 0);
        push_a({4{16'd1}}, {4{16'd1}}, 1'b1);
        expect_a("restart", 4, 4, 1, 0);

        // 4 * 32767^2 = 0xFFFC0004: clamps to 0x7FFF, wraps to 0x0004.
        a_sat_en = 1'b1;
        push_a({4{16'h7FFF}}, {4{16'h7FFF}}, 1'b1);
        expect_a("sat", 64'hFFFC0004, 16'h7FFF, 1, 0);
        a_sat_en = 1'b0;
        push_a({4{16'h7FFF}}, {4{16'h7FFF}}, 1'b1);
        expect_a("wrap", 64'hFFFC0004, 16'h0004, 1, 0);

        // Backpressure: frame k sums to k. Frame 1 in output, 2 in s1, 3..6 fill the FIFO.
        a_out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            push_a({48'd0, 16'(k)}, {48'd0, 16'd1}, 1'b1);
        end
        step();
        step();
        chk("bp_full_ready", a_in_ready,  0);
        chk("bp_held_valid", a_out_valid, 1);
        chk("bp_held_acc",   a_out_acc,   1);
        a_in_valid = 1'b1;
        a_sig      = {48'd0, 16'd7};
        a_coef     = {48'd0, 16'd1};
        a_in_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_wait_ready", a_in_ready, 0);
            chk("bp_stable_acc", a_out_acc,  1);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            expect_a($sformatf("bp%0d", k), k, k, 1, 0);
        end
        step();
        step();
        chk("bp_drained", a_out_valid, 0);

        // Mid-frame reset discards two non-last beats.
        push_a({4{16'd1}}, {4{16'd1}}, 1'b0);
        push_a({4{16'd1}}, {4{16'd1}}, 1'b0);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
        chk("mrst_in_ready",  a_in_ready,  1);
        chk("mrst_out_valid", a_out_valid, 0);
        chk("mrst_out_acc",   a_out_acc,   0);
        push_a({4{16'd1}}, {4{16'd1}}, 1'b1);
        expect_a("mrst", 4, 4, 1, 0);

        // Overflow on B: 40 * 16384 = 10 * 65536 wraps to 0, sticky ovf set.
        for (int i = 0; i < 40; i++) begin
            b_in_valid = 1'b1;
            b_sig      = 8'h80;
            b_coef     = 8'h80;
            b_in_last  = (i == 39);
            n = 0;
            while (!b_in_ready && n < 50) begin
                step();
                n++;
            end
            step();
        end
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 50) begin
            step();
            n++;
        end
        chk("ovf_valid", b_out_valid, 1);
        chk("ovf_acc",   b_out_acc,   0);
        chk("ovf_data",  b_out_data,  0);
        chk("ovf_beats", b_out_beats, 40);
        chk("ovf_flag",  b_out_ovf,   1);
        step();

        b_in_valid = 1'b1;
        b_sig      = 8'd3;
        b_coef     = 8'd5;
        b_in_last  = 1'b1;
        step();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 50) begin
            step();
            n++;
        end
        chk("novf_valid", b_out_valid, 1);
        chk("novf_acc",   b_out_acc,   15);
        chk("novf_data",  b_out_data,  15);
        chk("novf_beats", b_out_beats, 1);
        chk("novf_flag",  b_out_ovf,   0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
